// File: rtl/vga_timing_receiver.sv
// Receive-side VGA timing monitor: recovers pixel coordinates and sync strobes, measures
// line/frame geometry against the expected mode, declares lock and counts violations.
module vga_timing_receiver #(
  parameter int unsigned H_RES       = 640,
  parameter int unsigned V_RES       = 480,
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned V_TOTAL     = 525,
  parameter int unsigned SYNC_ACTIVE = 0,
  parameter int unsigned CORDW       = 16,
  parameter int unsigned ERRW        = 8
) (
  input  logic             clk_pix,
  input  logic             rst,
  input  logic             hsync,
  input  logic             vsync,
  input  logic             de,
  output logic [CORDW-1:0] rx_x,
  output logic [CORDW-1:0] rx_y,
  output logic             rx_valid,
  output logic             line_start,
  output logic             frame_start,
  output logic             locked,
  output logic [CORDW-1:0] h_total_meas,
  output logic [CORDW-1:0] v_total_meas,
  output logic             timing_err,
  output logic [ERRW-1:0]  err_count
);

  localparam logic             SyncLvl = (SYNC_ACTIVE != 0);
  localparam logic [CORDW-1:0] CntMax  = '1;
  localparam logic [CORDW-1:0] HRes    = CORDW'(H_RES);
  localparam logic [CORDW-1:0] VRes    = CORDW'(V_RES);
  localparam logic [CORDW-1:0] HTotal  = CORDW'(H_TOTAL);
  localparam logic [CORDW-1:0] VTotal  = CORDW'(V_TOTAL);

  typedef enum logic [1:0] {StSearch, StCheck, StLocked} state_e;

  function automatic logic [CORDW-1:0] sat_inc(input logic [CORDW-1:0] v);
    return (v == CntMax) ? v : v + CORDW'(1);
  endfunction

  logic hs1_q, vs1_q, de1_q, hs2_q, vs2_q, de2_q;
  logic [CORDW-1:0] h_cnt_q, h_cnt_d, act_cnt_q, act_cnt_d;
  logic [CORDW-1:0] v_cnt_q, v_cnt_d, act_lines_q, act_lines_d;
  logic [CORDW-1:0] h_meas_q, h_meas_d, v_meas_q, v_meas_d;
  logic [CORDW-1:0] rx_x_q, rx_x_d, rx_y_q, rx_y_d;
  logic             rx_valid_q, rx_valid_d, line_start_q, frame_start_q;
  logic             timing_err_q, timing_err_d, viol_seen_q, viol_seen_d;
  logic [ERRW-1:0]  err_cnt_q, err_cnt_d;
  state_e           state_q, state_d;

  logic             hs_edge, vs_edge, viol;
  logic [CORDW-1:0] line_len, line_act, frame_lines, frame_act;

  always_comb begin
    hs_edge  = (hs1_q == SyncLvl) && (hs2_q != SyncLvl);
    vs_edge  = (vs1_q == SyncLvl) && (vs2_q != SyncLvl);
    line_len = sat_inc(h_cnt_q);
    line_act = de1_q ? sat_inc(act_cnt_q) : act_cnt_q;

    // A line closing in the same cycle as the frame still belongs to that frame.
    frame_lines = hs_edge ? sat_inc(v_cnt_q) : v_cnt_q;
    frame_act   = (hs_edge && line_act != '0) ? sat_inc(act_lines_q) : act_lines_q;

    viol = (hs_edge && (line_len != HTotal || (line_act != '0 && line_act != HRes)))
        || (vs_edge && (frame_lines != VTotal || frame_act != VRes))
        || (!hs_edge && h_cnt_q == CntMax - CORDW'(1))
        || (hs_edge && !vs_edge && v_cnt_q == CntMax - CORDW'(1));

    h_cnt_d     = hs_edge ? '0 : sat_inc(h_cnt_q);
    act_cnt_d   = hs_edge ? '0 : line_act;
    v_cnt_d     = vs_edge ? '0 : frame_lines;
    act_lines_d = vs_edge ? '0 : frame_act;
    h_meas_d    = hs_edge ? line_len : h_meas_q;
    v_meas_d    = vs_edge ? frame_lines : v_meas_q;

    rx_x_d = rx_x_q;
    if (de1_q && !de2_q)  rx_x_d = '0;
    else if (de1_q)       rx_x_d = rx_x_q + CORDW'(1);
    rx_y_d = rx_y_q;
    if (vs_edge)             rx_y_d = '0;
    else if (!de1_q && de2_q) rx_y_d = rx_y_q + CORDW'(1);
    rx_valid_d = de1_q && (state_q == StLocked);
  end

  always_comb begin
    state_d      = state_q;
    viol_seen_d  = viol_seen_q;
    timing_err_d = 1'b0;
    err_cnt_d    = err_cnt_q;
    unique case (state_q)
      StSearch: begin
        if (vs_edge) begin
          state_d     = StCheck;
          viol_seen_d = 1'b0;
        end
      end
      StCheck: begin
        if (vs_edge) begin
          if (!(viol_seen_q || viol)) state_d = StLocked;
          viol_seen_d = 1'b0;
        end else if (viol) begin
          viol_seen_d = 1'b1;
        end
      end
      StLocked: begin
        if (viol) begin
          timing_err_d = 1'b1;
          err_cnt_d    = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + ERRW'(1);
          state_d      = StSearch;
        end
      end
      default: state_d = StSearch;
    endcase
  end

  always_ff @(posedge clk_pix) begin
    if (rst) begin
      // Sync stages start inactive so reset cannot fabricate a leading edge.
      {hs1_q, vs1_q, hs2_q, vs2_q} <= {4{~SyncLvl}};
      {de1_q, de2_q}               <= 2'b00;
      h_cnt_q       <= '0;
      act_cnt_q     <= '0;
      v_cnt_q       <= '0;
      act_lines_q   <= '0;
      h_meas_q      <= '0;
      v_meas_q      <= '0;
      rx_x_q        <= '0;
      rx_y_q        <= '0;
      rx_valid_q    <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      timing_err_q  <= 1'b0;
      viol_seen_q   <= 1'b0;
      err_cnt_q     <= '0;
      state_q       <= StSearch;
    end else begin
      {hs1_q, vs1_q, de1_q} <= {hsync, vsync, de};
      {hs2_q, vs2_q, de2_q} <= {hs1_q, vs1_q, de1_q};
      h_cnt_q       <= h_cnt_d;
      act_cnt_q     <= act_cnt_d;
      v_cnt_q       <= v_cnt_d;
      act_lines_q   <= act_lines_d;
      h_meas_q      <= h_meas_d;
      v_meas_q      <= v_meas_d;
      rx_x_q        <= rx_x_d;
      rx_y_q        <= rx_y_d;
      rx_valid_q    <= rx_valid_d;
      line_start_q  <= hs_edge;
      frame_start_q <= vs_edge;
      timing_err_q  <= timing_err_d;
      viol_seen_q   <= viol_seen_d;
      err_cnt_q     <= err_cnt_d;
      state_q       <= state_d;
    end
  end

  assign rx_x         = rx_x_q;
  assign rx_y         = rx_y_q;
  assign rx_valid     = rx_valid_q;
  assign line_start   = line_start_q;
  assign frame_start  = frame_start_q;
  assign locked       = (state_q == StLocked);
  assign h_total_meas = h_meas_q;
  assign v_total_meas = v_meas_q;
  assign timing_err   = timing_err_q;
  assign err_count    = err_cnt_q;

endmodule

// File: tb/tb_vga_timing_receiver.sv
// Directed bench for vga_timing_receiver on a reduced 8x4 mode (H 8/2/3/3, V 4/1/1/2).
module tb_vga_timing_receiver;

  localparam int unsigned HRes   = 8;
  localparam int unsigned VRes   = 4;
  localparam int unsigned HTotal = 16;
  localparam int unsigned VTotal = 8;
  localparam int unsigned CordW  = 8;
  localparam int unsigned ErrW   = 5;

  logic             clk_pix = 1'b0;
  logic             rst = 1'b1;
  logic             hsync = 1'b1;
  logic             vsync = 1'b1;
  logic             de = 1'b0;
  logic [CordW-1:0] rx_x, rx_y, h_total_meas, v_total_meas;
  logic             rx_valid, line_start, frame_start, locked, timing_err;
  logic [ErrW-1:0]  err_count;

  vga_timing_receiver #(
    .H_RES(HRes), .V_RES(VRes), .H_TOTAL(HTotal), .V_TOTAL(VTotal),
    .SYNC_ACTIVE(0), .CORDW(CordW), .ERRW(ErrW)
  ) u_dut (
    .clk_pix(clk_pix), .rst(rst), .hsync(hsync), .vsync(vsync), .de(de),
    .rx_x(rx_x), .rx_y(rx_y), .rx_valid(rx_valid), .line_start(line_start),
    .frame_start(frame_start), .locked(locked), .h_total_meas(h_total_meas),
    .v_total_meas(v_total_meas), .timing_err(timing_err), .err_count(err_count)
  );

  always #5 clk_pix = ~clk_pix;

  int cyc = 0;
  always @(posedge clk_pix) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;
  int hs_drive [8];
  int vs_drive = 0;

  // Observation side: pulse counters, strobe timestamps and a coordinate model.
  int   te_count = 0, te_cyc = -1, te_hmeas = -1, fs_cyc = -1, ls_cyc = -1, lock_cyc = -1;
  int   valid_cnt = 0, max_x = 0, max_y = 0, coord_bad = 0, last_y = 0;
  logic locked_prev = 1'b0, valid_prev = 1'b0, fs_seen = 1'b1;
  logic [CordW-1:0] x_prev = '0;

  always @(negedge clk_pix) begin
    if (timing_err) begin
      te_count <= te_count + 1;
      te_cyc   <= cyc;
      te_hmeas <= int'(h_total_meas);
    end
    if (frame_start) fs_cyc <= cyc;
    if (line_start) ls_cyc <= cyc;
    if (locked && !locked_prev) lock_cyc <= cyc;
    locked_prev <= locked;
    if (frame_start) fs_seen <= 1'b1;
    if (rx_valid) begin
      valid_cnt <= valid_cnt + 1;
      if (int'(rx_x) > max_x) max_x <= int'(rx_x);
      if (int'(rx_y) > max_y) max_y <= int'(rx_y);
      if (!valid_prev) begin
        if (rx_x != '0 || int'(rx_y) != (fs_seen ? 0 : last_y + 1)) coord_bad <= coord_bad + 1;
        last_y  <= fs_seen ? 0 : last_y + 1;
        fs_seen <= 1'b0;
      end else if (rx_x != x_prev + CordW'(1) || int'(rx_y) != last_y) begin
        coord_bad <= coord_bad + 1;
      end
    end
    valid_prev <= rx_valid;
    x_prev     <= rx_x;
  end

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic pix(input logic h, input logic v, input logic d);
    hsync = h;
    vsync = v;
    de    = d;
    @(posedge clk_pix);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) pix(1'b1, 1'b1, 1'b0);
  endtask

  task automatic run_line(input int l, input int len, input int dlen, input bit do_rst);
    for (int h = 0; h < len; h++) begin
      if (h == len - 6) hs_drive[l] = cyc;
      if (l == 5 && h == 0) vs_drive = cyc;
      if (do_rst && h == 4) rst = 1'b1;
      pix(!(h >= len - 6 && h < len - 3), l != 5, l < 4 && h < dlen);
      if (do_rst && h == 4) begin
        rst = 1'b0;
        check_eq("rst_mid_flags", {rx_valid, line_start, frame_start, locked, timing_err}, 0);
        check_eq("rst_mid_coords", {rx_x, rx_y}, 0);
        check_eq("rst_mid_meas", {h_total_meas, v_total_meas}, 0);
        check_eq("rst_mid_err_count", err_count, 0);
      end
    end
  endtask

  task automatic run_frame(input int stretch, input int wide, input int rst_l);
    for (int l = 0; l < 8; l++)
      run_line(l, (l == stretch) ? 17 : 16, (l == wide) ? 9 : 8, l == rst_l);
  endtask

  int te_base, v_base;

  initial begin
    idle(3);
    check_eq("reset_flags", {rx_valid, line_start, frame_start, locked, timing_err}, 0);
    check_eq("reset_coords", {rx_x, rx_y}, 0);
    check_eq("reset_meas", {h_total_meas, v_total_meas}, 0);
    check_eq("reset_err_count", err_count, 0);
    rst = 1'b0;

    // Nominal stream: lock at the second vsync edge.
    run_frame(-1, -1, -1);
    check_eq("not_locked_after_1_frame", locked, 0);
    run_frame(-1, -1, -1);
    check_eq("locked_after_2_frames", locked, 1);
    check_eq("lock_latency", lock_cyc, vs_drive + 2);
    check_eq("frame_start_latency", fs_cyc, vs_drive + 2);
    check_eq("line_start_latency", ls_cyc, hs_drive[7] + 2);
    check_eq("h_total_meas", h_total_meas, HTotal);
    check_eq("v_total_meas", v_total_meas, VTotal);
    v_base = valid_cnt;
    run_frame(-1, -1, -1);
    check_eq("valid_pixels_frame", valid_cnt - v_base, HRes * VRes);
    check_eq("max_rx_x", max_x, HRes - 1);
    check_eq("max_rx_y", max_y, VRes - 1);
    check_eq("coord_sequence", coord_bad, 0);
    check_eq("no_timing_err_nominal", te_count, 0);
    te_base = te_count;

    // One line stretched to 17 clocks.
    run_frame(1, -1, -1);
    check_eq("stretch_te_pulses", te_count - te_base, 1);
    check_eq("stretch_te_time", te_cyc, hs_drive[1] + 2);
    check_eq("stretch_h_meas_at_err", te_hmeas, HTotal + 1);
    check_eq("stretch_err_count", err_count, 1);
    check_eq("stretch_unlocked", locked, 0);
    run_frame(-1, -1, -1);
    run_frame(-1, -1, -1);
    check_eq("stretch_relocked", locked, 1);
    check_eq("stretch_err_count_hold", err_count, 1);

    // de held for 9 pixels on line 2.
    run_frame(-1, 2, -1);
    check_eq("wide_te_pulses", te_count - te_base, 2);
    check_eq("wide_te_time", te_cyc, hs_drive[2] + 2);
    check_eq("wide_h_meas_at_err", te_hmeas, HTotal);
    check_eq("wide_err_count", err_count, 2);
    check_eq("wide_unlocked", locked, 0);
    run_frame(-1, -1, -1);
    run_frame(-1, -1, -1);
    check_eq("wide_relocked", locked, 1);

    // Syncs stop: h counter runs to all-ones.
    idle(300);
    check_eq("lost_te_pulses", te_count - te_base, 3);
    check_eq("lost_te_time", te_cyc, hs_drive[7] + 257);
    check_eq("lost_err_count", err_count, 3);
    check_eq("lost_unlocked", locked, 0);
    idle(300);
    check_eq("lost_no_more_pulses", te_count - te_base, 3);
    run_frame(-1, -1, -1);
    run_frame(-1, -1, -1);
    check_eq("lost_relocked", locked, 1);

    // Reset for one cycle on line 2.
    run_frame(-1, -1, 2);
    check_eq("rst_not_locked_same_frame", locked, 0);
    te_base = te_count;
    run_frame(-1, -1, -1);
    check_eq("rst_relocked", locked, 1);
    check_eq("rst_err_count", err_count, 0);

    // Repeated violations saturate the error counter.
    for (int i = 0; i < 34; i++) begin
      run_frame(1, -1, -1);
      run_frame(-1, -1, -1);
    end
    check_eq("sat_te_pulses", te_count - te_base, 34);
    check_eq("sat_err_count", err_count, (1 << ErrW) - 1);
    check_eq("sat_locked", locked, 1);
    check_eq("coord_sequence_final", coord_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
